past_history_monitor: RTL and testbench

Parametrised multi-channel sample-history buffer with a built-in expected-value checker. It keeps the last DEPTH enabled samples of each of CHANNELS input streams and exposes any selected tap, giving synthesised RTL the same view `$past(data, k)` gives a formal property. It also compares a caller-supplied expected value against the selected tap and counts mismatches. It sits beside datapath blocks as a synthesisable history/scoreboard front-end for formal and simulation flows.

---
 rtl/past_history_monitor.sv | 146 ++++++++++++++
 tb/tb_past_history_monitor.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/past_history_monitor.sv
// past_history_monitor
// --------------------
// Multi-channel sample-history buffer with a built-in expected-value checker.
// It keeps the last DEPTH enabled samples of each of CHANNELS input streams.
// Any tap can be read back, which gives synthesised logic the same view that
// $past(data, k) gives a formal property. A caller-supplied expected value is
// compared against the selected tap, and failed comparisons are counted.
//
// Parameters:
//   WIDTH    - bits per channel sample
//   DEPTH    - history stages per channel (>= 1)
//   CHANNELS - number of independent input streams (>= 1)
//
// Ports:
//   clk            in   sole clock, all state updates on posedge
//   rst            in   synchronous active-high reset
//   en             in   sample strobe, history shifts only when high
//   data           in   channel c at bits [c*WIDTH +: WIDTH]
//   chan_sel       in   channel selected for tap readout
//   tap_sel        in   tap index, 0 = most recent stored sample
//   tap_data       out  combinational read of hist[chan_sel][tap_sel]
//   tap_valid      out  selected tap holds a real sample since reset
//   fill           out  stored samples per channel, saturating at DEPTH
//   expect_valid   in   request a comparison this cycle
//   expect_data    in   value expected at the selected tap
//   mismatch       out  registered one-cycle pulse on a failed comparison
//   mismatch_count out  saturating count of mismatches
//
// Optional feature macro: PAST_HISTORY_MONITOR_ASSERT_EN compiles in
// concurrent properties describing the history, fill and checker behaviour.

module past_history_monitor #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int CHANNELS = 2,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int TW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int FW = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [CHANNELS*WIDTH-1:0] data,
  input  logic [CW-1:0]             chan_sel,
  input  logic [TW-1:0]             tap_sel,
  output logic [WIDTH-1:0]          tap_data,
  output logic                      tap_valid,
  output logic [FW-1:0]             fill,
  input  logic                      expect_valid,
  input  logic [WIDTH-1:0]          expect_data,
  output logic                      mismatch,
  output logic [15:0]               mismatch_count
);

  logic [WIDTH-1:0] r_hist [CHANNELS][DEPTH];
  logic [FW-1:0]    r_fill;
  logic             r_mismatch;
  logic [15:0]      r_count;

  logic             w_chanOk;
  logic             w_tapOk;
  logic             w_tapValid;
  logic [WIDTH-1:0] w_tapData;
  logic             w_mismatchNext;

  // Shift register per channel; all channels advance together on en.
  // fill saturates at DEPTH so tap_valid knows how many stages are real.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < DEPTH; k++) begin
          r_hist[c][k] <= '0;
        end
      end
      r_fill <= '0;
    end else if (en) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_hist[c][0] <= data[c*WIDTH +: WIDTH];
        for (int k = 1; k < DEPTH; k++) begin
          r_hist[c][k] <= r_hist[c][k-1];
        end
      end
      if (r_fill != FW'(DEPTH)) begin
        r_fill <= r_fill + 1'b1;
      end
    end
  end

  // Out-of-range selects read as zero and invalid, so non-power-of-two
  // CHANNELS/DEPTH never index past the storage.
  always_comb begin
    w_chanOk   = (32'(chan_sel) < 32'(CHANNELS));
    w_tapOk    = (32'(tap_sel) < 32'(DEPTH));
    w_tapValid = w_chanOk && w_tapOk && (32'(tap_sel) < 32'(r_fill));
    w_tapData  = '0;
    if (w_chanOk && w_tapOk) begin
      w_tapData = r_hist[chan_sel][tap_sel];
    end
  end

  // The comparison uses the pre-shift tap visible this cycle. The counter
  // advances on the same edge that raises mismatch, so both reflect the
  // comparison together one cycle later.
  assign w_mismatchNext = expect_valid && w_tapValid && (expect_data != w_tapData);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mismatch <= 1'b0;
      r_count    <= '0;
    end else begin
      r_mismatch <= w_mismatchNext;
      if (w_mismatchNext && (r_count != 16'hFFFF)) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  assign tap_data       = w_tapData;
  assign tap_valid      = w_tapValid;
  assign fill           = r_fill;
  assign mismatch       = r_mismatch;
  assign mismatch_count = r_count;

`ifdef PAST_HISTORY_MONITOR_ASSERT_EN
  for (genvar gc = 0; gc < CHANNELS; gc++) begin : g_chanProps
    a_head: assert property (@(posedge clk) disable iff (rst)
      en |=> r_hist[gc][0] == $past(data[gc*WIDTH +: WIDTH]));
    for (genvar gk = 1; gk < DEPTH; gk++) begin : g_tapProps
      a_shift: assert property (@(posedge clk) disable iff (rst)
        en |=> r_hist[gc][gk] == $past(r_hist[gc][gk-1]));
    end
  end

  a_fillHold: assert property (@(posedge clk) disable iff (rst)
    !en |=> $stable(r_fill));
  a_fillMax: assert property (@(posedge clk) disable iff (rst)
    32'(r_fill) <= 32'(DEPTH));
  a_mismatchCause: assert property (@(posedge clk) disable iff (rst)
    r_mismatch |-> $past(expect_valid));
  // The first cycle out of reset has no meaningful previous count.
  a_countMono: assert property (@(posedge clk) disable iff (rst)
    !$past(rst) |-> r_count >= $past(r_count));
  c_mismatch: cover property (@(posedge clk) disable iff (rst) r_mismatch);
`endif

endmodule

// File: tb/tb_past_history_monitor.sv
// tb_past_history_monitor
// -----------------------
// Directed bench for past_history_monitor. One instance uses the default
// WIDTH=8, DEPTH=4, CHANNELS=2; a second uses CHANNELS=3, DEPTH=3 so that
// out-of-range selects can be exercised. Expected values are hand-computed.

module tb_past_history_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] data;
  logic        chanSel;
  logic [1:0]  tapSel;
  logic [7:0]  tapData;
  logic        tapValid;
  logic [2:0]  fill;
  logic        expectValid;
  logic [7:0]  expectData;
  logic        mismatch;
  logic [15:0] mismatchCount;

  logic        en3;
  logic [23:0] data3;
  logic [1:0]  chanSel3;
  logic [1:0]  tapSel3;
  logic [7:0]  tapData3;
  logic        tapValid3;
  logic [1:0]  fill3;
  logic        expectValid3;
  logic [7:0]  expectData3;
  logic        mismatch3;
  logic [15:0] mismatchCount3;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic       en;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [2:0] expFill;
  } fillVec_t;

  typedef struct {
    logic       chanSel;
    logic [1:0] tapSel;
    logic [7:0] expData;
    logic       expValid;
  } readVec_t;

  fillVec_t fillVecs [6];
  readVec_t readVecs [8];

  past_history_monitor #(.WIDTH(8), .DEPTH(4), .CHANNELS(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .data           (data),
    .chan_sel       (chanSel),
    .tap_sel        (tapSel),
    .tap_data       (tapData),
    .tap_valid      (tapValid),
    .fill           (fill),
    .expect_valid   (expectValid),
    .expect_data    (expectData),
    .mismatch       (mismatch),
    .mismatch_count (mismatchCount)
  );

  past_history_monitor #(.WIDTH(8), .DEPTH(3), .CHANNELS(3)) dut3 (
    .clk            (clk),
    .rst            (rst),
    .en             (en3),
    .data           (data3),
    .chan_sel       (chanSel3),
    .tap_sel        (tapSel3),
    .tap_data       (tapData3),
    .tap_valid      (tapValid3),
    .fill           (fill3),
    .expect_valid   (expectValid3),
    .expect_data    (expectData3),
    .mismatch       (mismatch3),
    .mismatch_count (mismatchCount3)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic enIn, input logic [7:0] d0, input logic [7:0] d1);
    en   = enIn;
    data = {d1, d0};
    tick();
  endtask

  initial begin
    rst          = 1'b1;
    en           = 1'b0;
    data         = '0;
    chanSel      = 1'b0;
    tapSel       = '0;
    expectValid  = 1'b0;
    expectData   = '0;
    en3          = 1'b0;
    data3        = '0;
    chanSel3     = '0;
    tapSel3      = '0;
    expectValid3 = 1'b0;
    expectData3  = '0;

    for (int i = 0; i < 6; i++) begin
      fillVecs[i].en      = 1'b1;
      fillVecs[i].d0      = 8'h10 + 8'(i);
      fillVecs[i].d1      = 8'h20 + 8'(i);
      fillVecs[i].expFill = (i < 3) ? 3'(i + 1) : 3'd4;
    end
    readVecs[0] = '{1'b0, 2'd0, 8'h15, 1'b1};
    readVecs[1] = '{1'b0, 2'd1, 8'h14, 1'b1};
    readVecs[2] = '{1'b0, 2'd2, 8'h13, 1'b1};
    readVecs[3] = '{1'b0, 2'd3, 8'h12, 1'b1};
    readVecs[4] = '{1'b1, 2'd0, 8'h25, 1'b1};
    readVecs[5] = '{1'b1, 2'd1, 8'h24, 1'b1};
    readVecs[6] = '{1'b1, 2'd2, 8'h23, 1'b1};
    readVecs[7] = '{1'b1, 2'd3, 8'h22, 1'b1};

    $display("[TB] reset with en and expect_valid active");
    tick();
    en          = 1'b1;
    expectValid = 1'b1;
    expectData  = 8'(($urandom() & 32'hFE) | 32'h01);
    for (int i = 0; i < 2; i++) begin
      data = 16'($urandom());
      tick();
    end
    checkOutput("reset tap_data", 32'(tapData), 0);
    checkOutput("reset tap_valid", 32'(tapValid), 0);
    checkOutput("reset fill", 32'(fill), 0);
    checkOutput("reset mismatch", 32'(mismatch), 0);
    checkOutput("reset count", 32'(mismatchCount), 0);
    rst         = 1'b0;
    en          = 1'b0;
    expectValid = 1'b0;
    tick();
    checkOutput("post-reset fill", 32'(fill), 0);

    $display("[TB] fill and wrap");
    for (int i = 0; i < 6; i++) begin
      en3   = (i < 3);
      data3 = {8'h60 + 8'(i), 8'h50 + 8'(i), 8'h40 + 8'(i)};
      applyStimulus(fillVecs[i].en, fillVecs[i].d0, fillVecs[i].d1);
      checkOutput($sformatf("fill step %0d", i), 32'(fill), 32'(fillVecs[i].expFill));
    end
    en  = 1'b0;
    en3 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chanSel = readVecs[i].chanSel;
      tapSel  = readVecs[i].tapSel;
      #1;
      checkOutput($sformatf("read c%0d t%0d data", readVecs[i].chanSel, readVecs[i].tapSel),
                  32'(tapData), 32'(readVecs[i].expData));
      checkOutput($sformatf("read c%0d t%0d valid", readVecs[i].chanSel, readVecs[i].tapSel),
                  32'(tapValid), 32'(readVecs[i].expValid));
    end

    $display("[TB] out-of-range selects on CHANNELS=3 DEPTH=3");
    checkOutput("dut3 fill", 32'(fill3), 3);
    chanSel3 = 2'd2; tapSel3 = 2'd2; #1;
    checkOutput("dut3 c2 t2 data", 32'(tapData3), 32'h60);
    checkOutput("dut3 c2 t2 valid", 32'(tapValid3), 1);
    chanSel3 = 2'd3; tapSel3 = 2'd0; #1;
    checkOutput("dut3 c3 data", 32'(tapData3), 0);
    checkOutput("dut3 c3 valid", 32'(tapValid3), 0);
    chanSel3 = 2'd0; tapSel3 = 2'd3; #1;
    checkOutput("dut3 t3 data", 32'(tapData3), 0);
    checkOutput("dut3 t3 valid", 32'(tapValid3), 0);

    $display("[TB] stall between writes");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 8'hA1, 8'h3C);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'($urandom()), 8'($urandom()));
      checkOutput($sformatf("stall fill %0d", i), 32'(fill), 1);
    end
    applyStimulus(1'b1, 8'hA2, 8'h77);
    en      = 1'b0;
    chanSel = 1'b0;
    tapSel  = 2'd0;
    #1;
    checkOutput("stall fill", 32'(fill), 2);
    checkOutput("stall tap0", 32'(tapData), 32'hA2);
    tapSel = 2'd1; #1;
    checkOutput("stall tap1", 32'(tapData), 32'hA1);

    $display("[TB] comparisons");
    chanSel     = 1'b1;
    tapSel      = 2'd1;
    expectValid = 1'b1;
    expectData  = 8'h3C;
    tick();
    expectValid = 1'b0;
    checkOutput("match mismatch", 32'(mismatch), 0);
    checkOutput("match count", 32'(mismatchCount), 0);
    expectValid = 1'b1;
    expectData  = 8'h3D;
    tick();
    expectValid = 1'b0;
    checkOutput("miss mismatch", 32'(mismatch), 1);
    checkOutput("miss count", 32'(mismatchCount), 1);
    tick();
    checkOutput("miss pulse end", 32'(mismatch), 0);
    checkOutput("miss count hold", 32'(mismatchCount), 1);
    tapSel = 2'd3; #1;
    checkOutput("invalid tap_valid", 32'(tapValid), 0);
    expectValid = 1'b1;
    expectData  = 8'h55;
    tick();
    expectValid = 1'b0;
    checkOutput("invalid mismatch", 32'(mismatch), 0);
    checkOutput("invalid count", 32'(mismatchCount), 1);

    // Compare against the pre-shift tap while a new sample is written.
    chanSel     = 1'b0;
    tapSel      = 2'd0;
    expectValid = 1'b1;
    expectData  = 8'hA2;
    applyStimulus(1'b1, 8'hB0, 8'hB1);
    en          = 1'b0;
    expectValid = 1'b0;
    checkOutput("pre-shift mismatch", 32'(mismatch), 0);
    checkOutput("pre-shift count", 32'(mismatchCount), 1);
    checkOutput("post-shift tap0", 32'(tapData), 32'hB0);
    checkOutput("post-shift fill", 32'(fill), 3);

    $display("[TB] back-to-back failures and saturation");
    expectValid = 1'b1;
    expectData  = 8'h4F;
    for (int i = 0; i < 65540; i++) begin
      tick();
      if (i == 1) begin
        checkOutput("b2b mismatch", 32'(mismatch), 1);
        checkOutput("b2b count", 32'(mismatchCount), 3);
      end
    end
    checkOutput("sat mismatch", 32'(mismatch), 1);
    checkOutput("sat count", 32'(mismatchCount), 32'hFFFF);

    $display("[TB] reset with a failing comparison in flight");
    rst = 1'b1;
    tick();
    checkOutput("rst mismatch", 32'(mismatch), 0);
    checkOutput("rst count", 32'(mismatchCount), 0);
    rst         = 1'b0;
    expectValid = 1'b0;
    tick();
    checkOutput("after rst mismatch", 32'(mismatch), 0);
    checkOutput("after rst count", 32'(mismatchCount), 0);
    checkOutput("after rst fill", 32'(fill), 0);
    applyStimulus(1'b1, 8'hC3, 8'hC4);
    en = 1'b0;
    checkOutput("first en fill", 32'(fill), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
